// File: rtl/problem3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : problem3_pkg
// Purpose  : Shared constants and types for the problem3 datapath family:
//            default word width and the pair-splitter FSM state encoding.
// Revision : 1.0  initial release
// ============================================================================
package problem3_pkg;

  // Default operand word width, shared with problem3.
  localparam int P3_W = 16;

  // Pair-splitter states, 2-bit encoding:
  //   S_P0  - waiting for the first word of a pair
  //   S_P1  - first word held, waiting for the second
  //   S_OUT - complete pair presented downstream
  typedef enum logic [1:0] {
    S_P0  = 2'd0,
    S_P1  = 2'd1,
    S_OUT = 2'd2
  } p3_split_state_e;

endpackage : problem3_pkg
`default_nettype wire

// File: rtl/problem3_split.sv
`default_nettype none
// ============================================================================
// Module   : problem3_split
// Purpose  : Regroups a serial stream of W-bit words (valid/ready) into
//            (p0, p1) pairs presented on two parallel outputs with their own
//            valid/ready handshake. Feeds problem3 from a single word source.
//            Optional build macro PROBLEM3_SPLIT_PAIRCNT_EN adds a 16-bit
//            pair counter (o_pair_cnt) and a flush-drop pulse (o_drop).
// Revision : 1.0  initial release
// ============================================================================
module problem3_split
  import problem3_pkg::*;
#(
  parameter int W = P3_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_p,
  input  logic         i_flush,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_p0,
  output logic [W-1:0] o_p1
`ifdef PROBLEM3_SPLIT_PAIRCNT_EN
  ,
  output logic [15:0]  o_pair_cnt,
  output logic         o_drop
`endif
);

  p3_split_state_e r_state;
  p3_split_state_e w_state_nxt;

  logic [W-1:0] r_p0;
  logic [W-1:0] r_p1;

  logic w_ready;
  logic w_valid;
  logic w_cap_p0;
  logic w_cap_p1;

  // State register; reset lands in S_P0 with no pair pending.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_P0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode. o_ready never depends on i_valid, only
  // on state, i_flush (in S_P1) and the downstream i_ready (in S_OUT).
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_valid     = 1'b0;
    w_cap_p0    = 1'b0;
    w_cap_p1    = 1'b0;
    case (r_state)
      S_P0: begin
        w_ready = 1'b1;
        if (i_valid) begin
          w_cap_p0    = 1'b1;
          w_state_nxt = S_P1;
        end
      end
      S_P1: begin
        // Flush wins over a same-cycle word; ready is withheld so upstream
        // keeps presenting that word rather than losing it.
        if (i_flush) begin
          w_state_nxt = S_P0;
        end else begin
          w_ready = 1'b1;
          if (i_valid) begin
            w_cap_p1    = 1'b1;
            w_state_nxt = S_OUT;
          end
        end
      end
      S_OUT: begin
        // A complete pair is never flushed. When the pair leaves, a word
        // arriving in the same cycle starts the next pair with no bubble.
        w_valid = 1'b1;
        w_ready = i_ready;
        if (i_ready) begin
          if (i_valid) begin
            w_cap_p0    = 1'b1;
            w_state_nxt = S_P1;
          end else begin
            w_state_nxt = S_P0;
          end
        end
      end
      default: begin
        w_state_nxt = S_P0;
      end
    endcase
  end

  // Pair data registers; hold their value whenever not being written.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_p0 <= '0;
      r_p1 <= '0;
    end else begin
      if (w_cap_p0) begin
        r_p0 <= i_p;
      end
      if (w_cap_p1) begin
        r_p1 <= i_p;
      end
    end
  end

  assign o_ready = w_ready;
  assign o_valid = w_valid;
  assign o_p0    = r_p0;
  assign o_p1    = r_p1;

`ifdef PROBLEM3_SPLIT_PAIRCNT_EN
  logic [15:0] r_pair_cnt;
  logic        r_drop;
  logic        w_out_xfer;
  logic        w_drop;

  assign w_out_xfer = w_valid & i_ready;
  // A held first word is discarded only by a flush while in S_P1.
  assign w_drop     = (r_state == S_P1) & i_flush;

  // Pair counter (wraps naturally) and one-cycle drop pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pair_cnt <= 16'd0;
      r_drop     <= 1'b0;
    end else begin
      if (w_out_xfer) begin
        r_pair_cnt <= r_pair_cnt + 16'd1;
      end
      r_drop <= w_drop;
    end
  end

  assign o_pair_cnt = r_pair_cnt;
  assign o_drop     = r_drop;
`endif

endmodule : problem3_split
`default_nettype wire

// File: tb/tb_problem3_split.sv
`default_nettype none
// ============================================================================
// Module   : tb_problem3_split
// Purpose  : Self-checking bench for problem3_split: directed scenarios plus
//            randomized traffic against a word/pair-level reference model.
//            Honours PROBLEM3_SPLIT_PAIRCNT_EN when defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_problem3_split;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_p;
  logic         i_flush;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_p0;
  logic [W-1:0] o_p1;
`ifdef PROBLEM3_SPLIT_PAIRCNT_EN
  logic [15:0]  o_pair_cnt;
  logic         o_drop;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: how many words of the next pair are collected (0/1),
  // the collected word, and whether a complete pair is waiting downstream.
  int           m_part_n;
  logic [W-1:0] m_part_w;
  logic         m_pv;
  logic [W-1:0] m_p0;
  logic [W-1:0] m_p1;
  int           m_cnt;
  logic         m_drop;

  problem3_split #(.W(W)) u_dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_p     (i_p),
    .i_flush (i_flush),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_p0    (o_p0),
    .o_p1    (o_p1)
`ifdef PROBLEM3_SPLIT_PAIRCNT_EN
    ,
    .o_pair_cnt (o_pair_cnt),
    .o_drop     (o_drop)
`endif
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_part_n = 0;
    m_part_w = '0;
    m_pv     = 1'b0;
    m_p0     = '0;
    m_p1     = '0;
    m_cnt    = 0;
    m_drop   = 1'b0;
  endtask

  // One clock cycle. Entered and left at posedge+1. Drives inputs, checks
  // outputs at the falling edge, then advances the model across the edge.
  task automatic cycle(input logic v, input logic [W-1:0] p, input logic f,
                       input logic r, output logic acc);
    logic exp_rdy;
    logic in_x;
    logic out_x;
    i_valid = v;
    i_p     = p;
    i_flush = f;
    i_ready = r;
    exp_rdy = m_pv ? r : !((m_part_n == 1) && f);
    @(negedge clk);
    check("o_ready", {31'd0, o_ready}, {31'd0, exp_rdy});
    check("o_valid", {31'd0, o_valid}, {31'd0, m_pv});
    if (m_pv) begin
      check("o_p0", {16'd0, o_p0}, {16'd0, m_p0});
      check("o_p1", {16'd0, o_p1}, {16'd0, m_p1});
    end
`ifdef PROBLEM3_SPLIT_PAIRCNT_EN
    check("o_pair_cnt", {16'd0, o_pair_cnt}, m_cnt & 32'hffff);
    check("o_drop", {31'd0, o_drop}, {31'd0, m_drop});
`endif
    @(posedge clk);
    in_x   = v && exp_rdy;
    out_x  = m_pv && r;
    m_drop = 1'b0;
    if (m_pv) begin
      if (out_x) begin
        m_pv  = 1'b0;
        m_cnt = m_cnt + 1;
        if (in_x) begin
          m_part_n = 1;
          m_part_w = p;
        end
      end
    end else if ((m_part_n == 1) && f) begin
      m_part_n = 0;
      m_drop   = 1'b1;
    end else if (in_x) begin
      if (m_part_n == 0) begin
        m_part_n = 1;
        m_part_w = p;
      end else begin
        m_pv     = 1'b1;
        m_p0     = m_part_w;
        m_p1     = p;
        m_part_n = 0;
      end
    end
    acc = in_x;
    #1;
  endtask

  // Async reset pulse placed between clock edges; outputs must clear at once.
  task automatic reset_pulse();
    i_valid = 1'b0;
    i_flush = 1'b0;
    i_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_o_valid", {31'd0, o_valid}, 32'd0);
    check("rst_o_p0", {16'd0, o_p0}, 32'd0);
    check("rst_o_p1", {16'd0, o_p1}, 32'd0);
    check("rst_o_ready", {31'd0, o_ready}, 32'd1);
`ifdef PROBLEM3_SPLIT_PAIRCNT_EN
    check("rst_o_pair_cnt", {16'd0, o_pair_cnt}, 32'd0);
`endif
    #1 rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic         acc;
    logic         cur_v;
    logic [W-1:0] cur_p;
    rst     = 1'b1;
    i_valid = 1'b0;
    i_p     = '0;
    i_flush = 1'b0;
    i_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("init_o_valid", {31'd0, o_valid}, 32'd0);
    check("init_o_p0", {16'd0, o_p0}, 32'd0);
    check("init_o_p1", {16'd0, o_p1}, 32'd0);
    check("init_o_ready", {31'd0, o_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic pairing.
    cycle(1'b1, 16'h0f0f, 1'b0, 1'b1, acc);
    cycle(1'b1, 16'h0f0f, 1'b0, 1'b1, acc);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, acc);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, acc);

    // Backpressure: pair held stable for 5 cycles, then a single transfer.
    cycle(1'b1, 16'h3366, 1'b0, 1'b0, acc);
    cycle(1'b1, 16'h6633, 1'b0, 1'b0, acc);
    repeat (5) cycle(1'b0, 16'h0000, 1'b0, 1'b0, acc);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, acc);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, acc);

    // Back-to-back pairs with continuous valid.
    cycle(1'b1, 16'h1234, 1'b0, 1'b1, acc);
    cycle(1'b1, 16'h5678, 1'b0, 1'b1, acc);
    cycle(1'b1, 16'h3366, 1'b0, 1'b1, acc);
    check("b2b_third_accepted", {31'd0, acc}, 32'd1);
    cycle(1'b1, 16'h6633, 1'b0, 1'b1, acc);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, acc);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, acc);

    // Flush with a same-cycle word: word refused, partial pair discarded.
    cycle(1'b1, 16'h1234, 1'b0, 1'b1, acc);
    cycle(1'b1, 16'h5678, 1'b1, 1'b1, acc);
    check("flush_word_refused", {31'd0, acc}, 32'd0);
    cycle(1'b1, 16'h3366, 1'b0, 1'b1, acc);
    cycle(1'b1, 16'h6633, 1'b0, 1'b1, acc);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, acc);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, acc);

    // Flush while a pair is pending is ignored.
    cycle(1'b1, 16'h0f0f, 1'b0, 1'b0, acc);
    cycle(1'b1, 16'h3366, 1'b0, 1'b0, acc);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, acc);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, acc);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, acc);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, acc);

    // Async reset mid-pair, then two fresh pairs.
    cycle(1'b1, 16'h1234, 1'b0, 1'b1, acc);
    reset_pulse();
    cycle(1'b1, 16'haaaa, 1'b0, 1'b1, acc);
    cycle(1'b1, 16'h5555, 1'b0, 1'b1, acc);
    cycle(1'b1, 16'hbeef, 1'b0, 1'b1, acc);
    cycle(1'b1, 16'hcafe, 1'b0, 1'b1, acc);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, acc);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, acc);

    // Randomized traffic; upstream holds its word until it is accepted.
    cur_v = 1'b0;
    cur_p = '0;
    acc   = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (!cur_v || acc) begin
        cur_v = ($urandom_range(0, 3) != 0);
        cur_p = W'($urandom);
      end
      cycle(cur_v, cur_p, ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0), acc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_problem3_split
`default_nettype wire

// File: doc/problem3_split.md
Name: problem3_split

Overview:
- Inverse-direction companion of the problem3 two-operand datapath.
- Accepts a single stream of W-bit words over valid/ready and regroups consecutive words into (p0, p1) pairs.
- Presents each pair on two parallel W-bit outputs with its own valid/ready handshake.
- Sits upstream of problem3 to feed its i_p0/i_p1 operands from one serial word source.

Parameters:
- W, 16, data word width; all data ports and pair registers are W bits.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  upstream word valid.
- o_ready  output  1  block can accept a word this cycle.
- i_p  input  W  upstream data word.
- i_flush  input  1  synchronous discard of a partially collected pair.
- o_valid  output  1  pair on o_p0/o_p1 is valid.
- i_ready  input  1  downstream accepts the pair this cycle.
- o_p0  output  W  first word of the pair (earlier arrival).
- o_p1  output  W  second word of the pair.

Behaviour:
- Reset (async, i_rst=1): state=S_P0, o_valid=0, o_p0=0, o_p1=0. o_ready is combinational and equals 1 in S_P0.
- Input transfer: i_valid & o_ready on a rising edge. Output transfer: o_valid & i_ready on a rising edge.
- FSM states:
  - S_P0: o_ready=1, o_valid=0. On input transfer, capture i_p into o_p0 and go to S_P1.
  - S_P1: o_ready=1, o_valid=0. On input transfer, capture i_p into o_p1 and go to S_OUT.
  - S_OUT: o_valid=1. o_ready=i_ready (a combinational pass-through is permitted; there is no comb path from i_valid to o_ready).
    - Output transfer without input transfer -> S_P0.
    - Output and input transfer in the same cycle -> capture i_p into o_p0 and go to S_P1 (pair-to-pair back-to-back, no bubble).
    - i_ready=0 -> hold; o_p0/o_p1 remain stable while o_valid=1.
- Latency: o_valid rises the cycle after the second word's transfer edge. Sustained throughput is one pair per 2 cycles.
- o_p0/o_p1 hold their last value when not being written. Stale values in S_P0/S_P1 are don't-care for checking.
- i_flush:
  - In S_P1, returns to S_P0 and discards the held o_p0 word. Flush has priority over a simultaneous input transfer: that word is dropped, and o_ready must be 0 while i_flush=1 so no word is silently lost.
  - In S_OUT, ignored; a complete pair is never dropped.
  - In S_P0, no effect.
- i_valid with o_ready=0: i_p and i_valid are held by upstream (standard rule). The block must not capture.
- Reset asserted mid-pair or mid-output: immediate return to reset values. Any partial or pending pair is lost.
- No arithmetic; words pass bit-exact.

Optional Feature:
- Macro: PROBLEM3_SPLIT_PAIRCNT_EN.
- Defined: adds output o_pair_cnt (16 bits) and output o_drop (1 bit).
  - o_pair_cnt increments on each output transfer and wraps 16'hffff -> 0. Reset value is 0.
  - o_drop pulses for 1 cycle whenever i_flush discards a held o_p0 word (S_P1 only). Reset value is 0.
- Undefined: neither port exists and there is no counter logic. Core behaviour is identical in both builds.

Decomposition:
- Shared package problem3_pkg holds:
  - state encoding localparams S_P0=2'd0, S_P1=2'd1, S_OUT=2'd2 (2-bit state type);
  - default width constant P3_W=16, reused by problem3.
- Sub-module: none. Single FSM plus two data registers. The optional counter stays inline under the macro.

Test Plan:
- Basic pairing: after reset, send 16'h0f0f then 16'h0f0f with i_ready=1 -> o_valid for 1 cycle with o_p0=0f0f, o_p1=0f0f. Then state S_P0, o_ready=1.
- Backpressure: send 3366, 6633 with i_ready=0 for 5 cycles -> o_valid held, o_p0=3366, o_p1=6633 stable, o_ready=0. Raise i_ready -> single transfer.
- Back-to-back: continuous i_valid with 1234, 5678, 3366, 6633 and i_ready=1 -> pairs (1234,5678) then (3366,6633) with no idle cycle between the S_OUT exit and the next capture. o_ready never drops for the third word.
- Flush: send 1234, then assert i_flush with i_valid=1, i_p=5678 -> word dropped, o_ready=0 that cycle, state S_P0. Next pair 3366/6633 emerges correctly.
- Flush in S_OUT: pair 0f0f/3366 pending and i_flush=1 -> pair retained, delivered intact when i_ready=1.
- Async reset mid-pair: after 1234 is accepted, pulse i_rst between clock edges -> o_valid=0, o_p0=0, o_p1=0 immediately. With PROBLEM3_SPLIT_PAIRCNT_EN, o_pair_cnt=0; it counts 1, 2 after two later pairs.
